// File: rtl/tone_period_meter.sv
// Measures the half-period of a clk-synchronous square wave in clk cycles,
// flags when consecutive measurements agree, and times out on a stalled input.
module tone_period_meter #(
    parameter int COUNTER_BITS = 12
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in,
    output logic [COUNTER_BITS-1:0] period,
    output logic                    valid,
    output logic                    locked,
    output logic                    timeout,
    output logic [1:0]              o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIRST = 2'd1,
        ST_MEAS  = 2'd2,
        ST_LOCK  = 2'd3
    } state_t;

    localparam logic [COUNTER_BITS-1:0] CNT_MAX = '1;
    localparam logic [COUNTER_BITS-1:0] CNT_ONE = COUNTER_BITS'(1);

    state_t                  r_state;
    logic                    r_in_q;
    logic                    r_in_prev;
    logic [COUNTER_BITS-1:0] r_cnt;
    logic [COUNTER_BITS-1:0] r_period;
    logic                    r_valid;
    logic                    r_locked;
    logic                    r_timeout;

    logic w_edge;
    logic w_sat;

    assign w_edge = r_in_q ^ r_in_prev;
    assign w_sat  = (r_cnt == CNT_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_in_q    <= 1'b0;
            r_in_prev <= 1'b0;
            r_cnt     <= '0;
            r_period  <= '0;
            r_valid   <= 1'b0;
            r_locked  <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_in_q    <= in;
            r_in_prev <= r_in_q;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;

            if (w_edge)
                r_cnt <= CNT_ONE;
            else if (!w_sat)
                r_cnt <= r_cnt + CNT_ONE;

            // An edge landing on a saturated count is a normal capture; only a
            // saturated count with no edge is a timeout.
            case (r_state)
                ST_IDLE: begin
                    if (w_edge)
                        r_state <= ST_FIRST;
                end
                ST_FIRST: begin
                    if (w_edge) begin
                        r_period <= r_cnt;
                        r_valid  <= 1'b1;
                        r_state  <= ST_MEAS;
                    end else if (w_sat) begin
                        r_timeout <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
                ST_MEAS: begin
                    if (w_edge) begin
                        r_period <= r_cnt;
                        r_valid  <= 1'b1;
                        if (r_cnt == r_period) begin
                            r_state  <= ST_LOCK;
                            r_locked <= 1'b1;
                        end
                    end else if (w_sat) begin
                        r_timeout <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
                ST_LOCK: begin
                    if (w_edge) begin
                        r_period <= r_cnt;
                        r_valid  <= 1'b1;
                        if (r_cnt != r_period) begin
                            r_state  <= ST_MEAS;
                            r_locked <= 1'b0;
                        end
                    end else if (w_sat) begin
                        r_timeout <= 1'b1;
                        r_locked  <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign period      = r_period;
    assign valid       = r_valid;
    assign locked      = r_locked;
    assign timeout     = r_timeout;
    assign o_dbg_state = r_state;

endmodule
